// File: rtl/dsrlzr_sipo_sync.sv
// Serial-in/parallel-out deserializer with sync-word alignment.
// Hunts for SYNC_WORD in an LSB-first bit stream, then emits aligned words
// and polices the periodic sync slot, dropping lock after repeated misses.
module dsrlzr_sipo_sync #(
    parameter int unsigned            DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]  SYNC_WORD   = 8'hA5,
    parameter int unsigned            SYNC_PERIOD = 16,
    parameter int unsigned            MISS_LIMIT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iSRL_IN,
    input  logic                  iBIT_EN,
    output logic [DATA_WIDTH-1:0] oDATA_OUT,
    output logic                  oDATA_VALID,
    output logic                  oLOCK,
    output logic                  oSYNC_ERR,
    output logic [7:0]            oERR_CNT
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH);
    localparam int unsigned WCW = $clog2(SYNC_PERIOD + 1);
    localparam int unsigned MCW = $clog2(MISS_LIMIT + 1);

    localparam logic [BCW-1:0] LastBit    = BCW'(DATA_WIDTH - 1);
    localparam logic [WCW-1:0] SyncSlot   = WCW'(SYNC_PERIOD);
    // A mismatch while miss_cnt sits here is the one that breaks lock.
    localparam logic [MCW-1:0] MissFinal  = MCW'(MISS_LIMIT - 1);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic [MCW-1:0]        miss_cnt_q, miss_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sync_err_q, sync_err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0] nxt;

    // Next-state: shift on strobe, hunt for alignment or frame locked words.
    always_comb begin
        nxt        = {iSRL_IN, sr_q[DATA_WIDTH-1:1]};
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_d     = data_q;
        err_cnt_d  = err_cnt_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;

        if (iBIT_EN) begin
            sr_d = nxt;
            unique case (state_q)
                StHunt: begin
                    if (nxt == SYNC_WORD) begin
                        state_d    = StLocked;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        miss_cnt_d = '0;
                    end
                end
                StLocked: begin
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q < SyncSlot) begin
                            data_d     = nxt;
                            valid_d    = 1'b1;
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end else begin
                            word_cnt_d = '0;
                            if (nxt == SYNC_WORD) begin
                                miss_cnt_d = '0;
                            end else begin
                                sync_err_d = 1'b1;
                                if (err_cnt_q != 8'hFF) begin
                                    err_cnt_d = err_cnt_q + 8'd1;
                                end
                                if (miss_cnt_q == MissFinal) begin
                                    // SR is kept so hunting resumes on the next strobe.
                                    state_d    = StHunt;
                                    miss_cnt_d = '0;
                                end else begin
                                    miss_cnt_d = miss_cnt_q + MCW'(1);
                                end
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // State register with synchronous reset; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHunt;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            miss_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign oDATA_OUT   = data_q;
    assign oDATA_VALID = valid_q;
    assign oLOCK       = (state_q == StLocked);
    assign oSYNC_ERR   = sync_err_q;
    assign oERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_dsrlzr_sipo_sync.sv
// Scoreboard bench for dsrlzr_sipo_sync: stimulus pushes expected words,
// a monitor pops them on every oDATA_VALID and checks value and latency.
module tb_dsrlzr_sipo_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iSRL_IN = 1'b0;
    logic       iBIT_EN = 1'b0;
    logic [7:0] oDATA_OUT;
    logic       oDATA_VALID;
    logic       oLOCK;
    logic       oSYNC_ERR;
    logic [7:0] oERR_CNT;

    dsrlzr_sipo_sync #(
        .DATA_WIDTH (8),
        .SYNC_WORD  (8'hA5),
        .SYNC_PERIOD(16),
        .MISS_LIMIT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iSRL_IN    (iSRL_IN),
        .iBIT_EN    (iBIT_EN),
        .oDATA_OUT  (oDATA_OUT),
        .oDATA_VALID(oDATA_VALID),
        .oLOCK      (oLOCK),
        .oSYNC_ERR  (oSYNC_ERR),
        .oERR_CNT   (oERR_CNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] w;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   gap = 0;
    int   sync_err_seen = 0;
    int   exp_err = 0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (oDATA_VALID) begin
            chk("valid_width", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", int'(oDATA_OUT), -1);
            end else begin
                e = exp_q.pop_front();
                chk("data_word", int'(oDATA_OUT), int'(e.w));
                chk("data_latency_cycle", cyc, e.c);
            end
        end
        if (oSYNC_ERR) begin
            sync_err_seen++;
            chk("sync_err_width", int'(prev_err), 0);
        end
        prev_valid = oDATA_VALID;
        prev_err   = oSYNC_ERR;
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        iBIT_EN = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_data_out", int'(oDATA_OUT), 0);
        chk("rst_valid", int'(oDATA_VALID), 0);
        chk("rst_lock", int'(oLOCK), 0);
        chk("rst_sync_err", int'(oSYNC_ERR), 0);
        chk("rst_err_cnt", int'(oERR_CNT), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_err = sync_err_seen;
    endtask

    // One strobed bit, followed by gap idle cycles; expected word is pushed
    // at the sampling edge, due in the cycle right after it.
    task automatic send_bit(input logic b, input logic push, input logic [7:0] w);
        exp_t e;
        @(negedge clk);
        iSRL_IN = b;
        iBIT_EN = 1'b1;
        @(posedge clk);
        if (push) begin
            e.w = w;
            e.c = cyc + 1;
            exp_q.push_back(e);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            iBIT_EN = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic expect_out);
        for (int i = 0; i < 8; i++) send_bit(w[i], (i == 7) && expect_out, w);
    endtask

    task automatic send_data_block();
        for (int k = 0; k < 16; k++) send_word(8'(k), 1'b1);
    endtask

    task automatic check_lock(input string name, input int req);
        #1;
        chk(name, int'(oLOCK), req);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        iBIT_EN = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        // 1: clean frame
        do_reset(2);
        send_word(8'hA5, 1'b0);
        check_lock("s1_lock_after_sync", 1);
        send_data_block();
        send_word(8'hA5, 1'b0);
        idle(2);
        chk("s1_sync_errs", sync_err_seen - exp_err, 0);
        chk("s1_err_cnt", int'(oERR_CNT), 0);
        chk("s1_lock_held", int'(oLOCK), 1);

        // 2: misaligned preamble, then scenario 3 continues locked
        do_reset(2);
        send_bit(1'b1, 1'b0, 8'h00);
        send_bit(1'b1, 1'b0, 8'h00);
        send_bit(1'b0, 1'b0, 8'h00);
        check_lock("s2_no_lock_preamble", 0);
        send_word(8'hA5, 1'b0);
        check_lock("s2_lock_after_sync", 1);
        send_data_block();
        send_word(8'hA5, 1'b0);
        check_lock("s2_lock_held", 1);

        // 3: one bad sync, good sync, later another single bad sync
        send_data_block();
        send_word(8'h5A, 1'b0);
        check_lock("s3_lock_after_bad1", 1);
        idle(1);
        chk("s3_err_cnt_1", int'(oERR_CNT), 1);
        chk("s3_sync_errs_1", sync_err_seen - exp_err, 1);
        send_data_block();
        send_word(8'hA5, 1'b0);
        send_data_block();
        send_word(8'h5A, 1'b0);
        check_lock("s3_lock_after_bad2", 1);
        send_data_block();
        send_word(8'hA5, 1'b0);
        idle(1);
        chk("s3_err_cnt_2", int'(oERR_CNT), 2);
        chk("s3_lock_end", int'(oLOCK), 1);

        // 4: two consecutive bad sync slots drop lock
        do_reset(2);
        send_word(8'hA5, 1'b0);
        send_data_block();
        send_word(8'h00, 1'b0);
        check_lock("s4_lock_after_miss1", 1);
        send_data_block();
        send_word(8'h00, 1'b0);
        check_lock("s4_lock_after_miss2", 0);
        idle(1);
        chk("s4_err_cnt", int'(oERR_CNT), 2);
        chk("s4_sync_errs", sync_err_seen - exp_err, 2);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        check_lock("s4_still_hunting", 0);
        send_word(8'hA5, 1'b0);
        check_lock("s4_relock", 1);
        send_word(8'h3C, 1'b1);
        send_word(8'hC3, 1'b1);
        send_word(8'h7E, 1'b1);

        // 5: scenario 1 with a strobe every 4th clock
        do_reset(2);
        gap = 3;
        send_word(8'hA5, 1'b0);
        chk("s5_lock_after_sync", int'(oLOCK), 1);
        send_data_block();
        send_word(8'hA5, 1'b0);
        gap = 0;
        idle(2);
        chk("s5_err_cnt", int'(oERR_CNT), 0);
        chk("s5_lock_held", int'(oLOCK), 1);

        // 6: reset mid-word, then relock on a fresh sync
        do_reset(2);
        send_word(8'hA5, 1'b0);
        send_word(8'h00, 1'b1);
        send_word(8'h01, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0 ^ (i == 1), 1'b0, 8'h00);
        do_reset(1);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 8'h00);
        send_word(8'h03, 1'b0);
        check_lock("s6_no_lock_before_sync", 0);
        send_word(8'hA5, 1'b0);
        check_lock("s6_relock", 1);
        send_word(8'h10, 1'b1);
        send_word(8'h20, 1'b1);
        idle(3);
        chk("s6_err_cnt", int'(oERR_CNT), 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
